// File: rtl/dac_ok_interface_if.sv
// Host-side signal bundle for the DAC bridge: byte load, trigger and the
// serial DAC pins, with host (master) and bridge (slave) views.
interface dac_ok_interface_if;
  logic       din_en;
  logic [7:0] din;
  logic       set_trig;
  logic       ack_data;
  logic       ack_set;
  logic       dac_din;
  logic       dac_cs;

  modport master (
    output din_en, din, set_trig,
    input  ack_data, ack_set, dac_din, dac_cs
  );

  modport slave (
    input  din_en, din, set_trig,
    output ack_data, ack_set, dac_din, dac_cs
  );
endinterface

// File: rtl/dac_ok_interface.sv
// Host-to-DAC bridge: assembles NBYTES host bytes into a word, then on a
// set_trig rising edge shifts it MSB-first to the DAC under active-low CS.
module dac_ok_interface #(
  parameter int NBYTES = 3,
  parameter int WIDTH  = 8*NBYTES
) (
  input logic               clk,
  input logic               rst,
  dac_ok_interface_if.slave bus
);
  localparam int BCW = $clog2(NBYTES + 1);
  localparam int SCW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BCW-1:0]   bcnt_q;
  logic [SCW-1:0]   bitcnt_q;
  logic             set_trig_q;
  logic             start;
  logic             last_byte;
  logic             ack_data_q;
  logic             ack_set_q;
  logic             dac_din_q;
  logic             dac_cs_q;

  always_comb begin
    buf_d     = {buf_q[WIDTH-9:0], bus.din};
    last_byte = bus.din_en && (bcnt_q == BCW'(NBYTES - 1));
    start     = bus.set_trig & ~set_trig_q;
  end

  // Byte assembly; a completed word is copied to hold and acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q      <= '0;
      hold_q     <= '0;
      bcnt_q     <= '0;
      ack_data_q <= 1'b0;
    end else begin
      ack_data_q <= last_byte;
      if (bus.din_en) begin
        buf_q <= buf_d;
        if (last_byte) begin
          hold_q <= buf_d;
          bcnt_q <= '0;
        end else begin
          bcnt_q <= bcnt_q + BCW'(1);
        end
      end
    end
  end

  // Pins are registered from the current state, so they trail the state by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      set_trig_q <= 1'b0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      dac_cs_q   <= 1'b1;
      dac_din_q  <= 1'b0;
      ack_set_q  <= 1'b0;
    end else begin
      set_trig_q <= bus.set_trig;
      dac_cs_q   <= 1'b1;
      dac_din_q  <= 1'b0;
      ack_set_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q  <= hold_q;
            bitcnt_q <= SCW'(WIDTH - 1);
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          dac_cs_q  <= 1'b0;
          dac_din_q <= shreg_q[WIDTH-1];
          shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_q  <= bitcnt_q - SCW'(1);
          if (bitcnt_q == '0) state_q <= DONE;
        end
        DONE: begin
          ack_set_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_data = ack_data_q;
  assign bus.ack_set  = ack_set_q;
  assign bus.dac_din  = dac_din_q;
  assign bus.dac_cs   = dac_cs_q;
endmodule

// File: tb/tb_dac_ok_interface.sv
// Self-checking bench for dac_ok_interface: directed scenarios plus random
// traffic, compared cycle by cycle against a word/timeline reference model.
module tb_dac_ok_interface;
  localparam int NB = 3;
  localparam int W  = 8*NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dac_ok_interface_if bus ();

  dac_ok_interface #(.NBYTES(NB), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model state: word assembly, last full word, frame timeline.
  longint     cyc = 0;
  int         pcnt;
  logic [W-1:0] pword, hold_m, fword;
  logic       trig_prev, active;
  longint     t0;
  logic       e_cs, e_din, e_ack_set, e_ack_data;

  // Monitor state: captured serial bits and event counters.
  logic [W-1:0] cap, last_frame;
  int         capn, last_bits, frames, ackd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pcnt = 0; pword = '0; hold_m = '0; trig_prev = 1'b0; active = 1'b0;
    e_cs = 1'b1; e_din = 1'b0; e_ack_set = 1'b0; e_ack_data = 1'b0;
    cap = '0; capn = 0;
  endtask

  task automatic model_edge();
    logic st;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    st = bus.set_trig && !trig_prev;
    trig_prev = bus.set_trig;
    if (st && (!active || cyc >= t0 + W + 2)) begin
      active = 1'b1; t0 = cyc; fword = hold_m;
    end
    e_ack_data = 1'b0;
    if (bus.din_en) begin
      pword = {pword[W-9:0], bus.din};
      pcnt++;
      if (pcnt == NB) begin
        hold_m = pword; pcnt = 0; e_ack_data = 1'b1;
      end
    end
    e_cs = 1'b1; e_din = 1'b0; e_ack_set = 1'b0;
    if (active && cyc >= t0 + 1 && cyc <= t0 + W) begin
      e_cs  = 1'b0;
      e_din = fword[W - 1 - int'(cyc - t0 - 1)];
    end
    if (active && cyc == t0 + W + 1) e_ack_set = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cs", 32'(bus.dac_cs), 32'(e_cs));
    chk("din", 32'(bus.dac_din), 32'(e_din));
    chk("ack_set", 32'(bus.ack_set), 32'(e_ack_set));
    chk("ack_data", 32'(bus.ack_data), 32'(e_ack_data));
    if (bus.dac_cs === 1'b0) begin
      cap = {cap[W-2:0], bus.dac_din}; capn++;
    end
    if (bus.ack_set === 1'b1) begin
      last_frame = cap; last_bits = capn; frames++; cap = '0; capn = 0;
    end
    if (bus.ack_data === 1'b1) ackd++;
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    bus.din_en = 1'b1; bus.din = b;
    tick();
    bus.din_en = 1'b0; bus.din = '0;
    repeat (gap) tick();
  endtask

  task automatic load_word(input logic [W-1:0] w);
    put_byte(w[23:16], 0); put_byte(w[15:8], 0); put_byte(w[7:0], 0);
  endtask

  task automatic trigger();
    bus.set_trig = 1'b1;
    tick();
    bus.set_trig = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input logic [W-1:0] exp, input int f0);
    int n = 0;
    while (frames == f0 && n < 80) begin tick(); n++; end
    if (frames == f0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, "_word"}, 32'(last_frame), 32'(exp));
      chk({tag, "_bits"}, 32'(last_bits), 32'(W));
    end
  endtask

  initial begin
    int f0, a0, n;
    bus.din_en = 1'b0; bus.din = '0; bus.set_trig = 1'b0;
    frames = 0; ackd = 0;
    model_reset();

    // Reset held several cycles, then released with no spurious pulses.
    repeat (4) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("rst_frames", 32'(frames), 32'd0);
    chk("rst_ackd", 32'(ackd), 32'd0);

    // Word load and send.
    a0 = ackd;
    load_word(24'hFF00AA);
    tick();
    chk("load_ackd", 32'(ackd - a0), 32'd1);
    f0 = frames;
    trigger();
    wait_frame("ff00aa", 24'hFF00AA, f0);

    // Gapped bytes keep the partial word.
    a0 = ackd;
    put_byte(8'h12, 5);
    put_byte(8'h34, 2);
    chk("gap_no_ack", 32'(ackd - a0), 32'd0);
    put_byte(8'h56, 1);
    chk("gap_ackd", 32'(ackd - a0), 32'd1);
    f0 = frames;
    trigger();
    wait_frame("gap", 24'h123456, f0);

    // Second trigger mid-SHIFT is ignored.
    f0 = frames;
    trigger();
    repeat (10) tick();
    trigger();
    wait_frame("busy", 24'h123456, f0);
    repeat (40) tick();
    chk("busy_frames", 32'(frames - f0), 32'd1);

    // Held trigger yields a single frame.
    f0 = frames;
    bus.set_trig = 1'b1;
    repeat (40) tick();
    bus.set_trig = 1'b0;
    repeat (10) tick();
    chk("held_frames", 32'(frames - f0), 32'd1);
    chk("held_word", 32'(last_frame), 32'h123456);

    // Loading during a transfer only affects the next frame.
    load_word(24'hFF00AA);
    f0 = frames;
    trigger();
    repeat (5) tick();
    load_word(24'h0F0F0F);
    wait_frame("midload_old", 24'hFF00AA, f0);
    tick();
    f0 = frames;
    trigger();
    wait_frame("midload_new", 24'h0F0F0F, f0);

    // Asynchronous reset at bit 10 aborts the frame and clears hold.
    put_byte(8'hA5, 0);
    f0 = frames;
    trigger();
    n = 0;
    while (capn < 10 && n < 40) begin tick(); n++; end
    chk("arst_reach_bit10", 32'(capn), 32'd10);
    rst = 1'b0;
    #1;
    chk("arst_cs", 32'(bus.dac_cs), 32'd1);
    chk("arst_din", 32'(bus.dac_din), 32'd0);
    chk("arst_ack_set", 32'(bus.ack_set), 32'd0);
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    repeat (30) tick();
    chk("arst_no_frame", 32'(frames - f0), 32'd0);
    trigger();
    wait_frame("arst_zero", 24'h000000, f0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.din_en = 1'($urandom_range(0, 1));
      bus.din    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.set_trig = ~bus.set_trig;
      tick();
    end
    bus.din_en = 1'b0; bus.set_trig = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
